// File: rtl/cache_hier_nway_pkg.sv
// Shared types and width helpers for the two-level N-way read-only cache hierarchy.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    L1_LOOK,
    L2_LOOK,
    MEM_WAIT,
    FILL,
    RESP
  } state_t;

  // Width helpers so both cache levels derive index/tag/age widths identically.
  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_width, input int sets);
    return addr_width - $clog2(sets);
  endfunction

  function automatic int age_w(input int ways);
    return $clog2(ways);
  endfunction

endpackage

// File: rtl/cache_hier_nway_if.sv
// Request/response, backing-memory and statistics bundle of the cache hierarchy.
interface cache_hier_nway_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  resp_l1_hit;
  logic                  resp_l2_hit;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [CNT_WIDTH-1:0]  l1_hit_cnt;
  logic [CNT_WIDTH-1:0]  l2_hit_cnt;
  logic [CNT_WIDTH-1:0]  miss_cnt;

  // Master is the core plus memory model; slave is the cache.
  modport master (
    output req_valid, req_addr, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_data, resp_l1_hit, resp_l2_hit,
           mem_req, mem_addr, l1_hit_cnt, l2_hit_cnt, miss_cnt
  );

  modport slave (
    input  req_valid, req_addr, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_data, resp_l1_hit, resp_l2_hit,
           mem_req, mem_addr, l1_hit_cnt, l2_hit_cnt, miss_cnt
  );
endinterface

// File: rtl/cache_nway_array.sv
// One cache level: tag/valid/data storage, true-LRU ages, combinational lookup,
// synchronous fill and touch.
module cache_nway_array
  import cache_pkg::*;
#(
  parameter int SETS       = 4,
  parameter int WAYS       = 4,
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_WIDTH-1:0]    addr,
  output logic                     hit,
  output logic [$clog2(WAYS)-1:0]  hit_way,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic [$clog2(WAYS)-1:0]  victim_way,
  input  logic                     touch_en,
  input  logic [$clog2(WAYS)-1:0]  touch_way,
  input  logic                     fill_en,
  input  logic [$clog2(WAYS)-1:0]  fill_way,
  input  logic [DATA_WIDTH-1:0]    fill_data
);

  localparam int IDX_W = idx_w(SETS);
  localparam int TAG_W = tag_w(ADDR_WIDTH, SETS);
  localparam int AGE_W = age_w(WAYS);

  logic [SETS-1:0][WAYS-1:0] valid_q;
  logic [TAG_W-1:0]          tag_q  [SETS][WAYS];
  logic [DATA_WIDTH-1:0]     data_q [SETS][WAYS];
  logic [AGE_W-1:0]          age_q  [SETS][WAYS];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             found_inv;
  logic             upd_en;
  logic [AGE_W-1:0] upd_way;

  assign idx     = addr[IDX_W-1:0];
  assign tag     = addr[ADDR_WIDTH-1:IDX_W];
  assign upd_en  = touch_en | fill_en;
  assign upd_way = fill_en ? fill_way : touch_way;

  // NOTE: every output of a combinational block is defaulted first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    hit        = 1'b0;
    hit_way    = '0;
    rd_data    = '0;
    victim_way = '0;
    found_inv  = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
        rd_data = data_q[idx][w];
      end
    end
    // Lowest-index invalid way wins; a full set gives up its oldest way.
    for (int w = 0; w < WAYS; w++) begin
      if (!found_inv && !valid_q[idx][w]) begin
        found_inv  = 1'b1;
        victim_way = AGE_W'(w);
      end
    end
    if (!found_inv) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[idx][w] == AGE_W'(WAYS - 1)) victim_way = AGE_W'(w);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, e.g. the touched way's old age below.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= AGE_W'(w);
      end
    end else begin
      if (fill_en) valid_q[idx][fill_way] <= 1'b1;
      if (upd_en) begin
        for (int w = 0; w < WAYS; w++) begin
          if (AGE_W'(w) == upd_way)                    age_q[idx][w] <= '0;
          else if (age_q[idx][w] < age_q[idx][upd_way]) age_q[idx][w] <= age_q[idx][w] + 1'b1;
        end
      end
    end
  end

  // NOTE: tag and data arrays are not reset; the valid bits alone decide
  // whether their contents are meaningful, so they can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[idx][fill_way]  <= tag;
      data_q[idx][fill_way] <= fill_data;
    end
  end

endmodule

// File: rtl/cache_hier_nway.sv
// Two-level read-only cache: request FSM, L1/L2 lookup and fill sequencing,
// backing-memory handshake and saturating hit/miss statistics.
module cache_hier_nway
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int WAYS       = 4,
  parameter int L1_SETS    = 4,
  parameter int L2_SETS    = 16,
  parameter int CNT_WIDTH  = 16
) (
  input logic              clk,
  input logic              rst,
  cache_hier_nway_if.slave bus
);

  localparam int WAY_W = age_w(WAYS);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  l1_hit_q, l2_hit_q;
  logic [CNT_WIDTH-1:0]  l1_cnt_q, l2_cnt_q, miss_cnt_q;

  logic                  l1_hit, l2_hit;
  logic [WAY_W-1:0]      l1_hit_way, l2_hit_way, l1_victim, l2_victim;
  logic [DATA_WIDTH-1:0] l1_data, l2_data;
  logic                  l1_touch, l2_touch, l1_fill, l2_fill;

  cache_nway_array #(
    .SETS(L1_SETS), .WAYS(WAYS), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)
  ) u_l1 (
    .clk(clk), .rst(rst), .addr(addr_q),
    .hit(l1_hit), .hit_way(l1_hit_way), .rd_data(l1_data), .victim_way(l1_victim),
    .touch_en(l1_touch), .touch_way(l1_hit_way),
    .fill_en(l1_fill), .fill_way(l1_victim), .fill_data(data_q)
  );

  cache_nway_array #(
    .SETS(L2_SETS), .WAYS(WAYS), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)
  ) u_l2 (
    .clk(clk), .rst(rst), .addr(addr_q),
    .hit(l2_hit), .hit_way(l2_hit_way), .rd_data(l2_data), .victim_way(l2_victim),
    .touch_en(l2_touch), .touch_way(l2_hit_way),
    .fill_en(l2_fill), .fill_way(l2_victim), .fill_data(data_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    l1_touch = 1'b0;
    l2_touch = 1'b0;
    l1_fill  = 1'b0;
    l2_fill  = 1'b0;
    case (state_q)
      IDLE:     if (bus.req_valid) state_d = L1_LOOK;
      L1_LOOK: begin
        l1_touch = l1_hit;
        state_d  = l1_hit ? RESP : L2_LOOK;
      end
      L2_LOOK: begin
        l2_touch = l2_hit;
        state_d  = l2_hit ? FILL : MEM_WAIT;
      end
      MEM_WAIT: if (bus.mem_ack) state_d = FILL;
      FILL: begin
        // An L2 hit already sits in L2; only memory data is written to both levels.
        l1_fill = 1'b1;
        l2_fill = !l2_hit_q;
        state_d = RESP;
      end
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      data_q     <= '0;
      l1_hit_q   <= 1'b0;
      l2_hit_q   <= 1'b0;
      l1_cnt_q   <= '0;
      l2_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.req_valid) begin
          addr_q   <= bus.req_addr;
          l1_hit_q <= 1'b0;
          l2_hit_q <= 1'b0;
        end
        L1_LOOK: if (l1_hit) begin
          data_q   <= l1_data;
          l1_hit_q <= 1'b1;
        end
        L2_LOOK: if (l2_hit) begin
          data_q   <= l2_data;
          l2_hit_q <= 1'b1;
        end
        MEM_WAIT: if (bus.mem_ack) data_q <= bus.mem_rdata;
        RESP: begin
          if (l1_hit_q) begin
            if (l1_cnt_q != '1) l1_cnt_q <= l1_cnt_q + 1'b1;
          end else if (l2_hit_q) begin
            if (l2_cnt_q != '1) l2_cnt_q <= l2_cnt_q + 1'b1;
          end else begin
            if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode the asynchronously reset state, so reset drops them at once.
  assign bus.req_ready   = (state_q == IDLE);
  assign bus.resp_valid  = (state_q == RESP);
  assign bus.resp_data   = bus.resp_valid ? data_q : '0;
  assign bus.resp_l1_hit = bus.resp_valid & l1_hit_q;
  assign bus.resp_l2_hit = bus.resp_valid & l2_hit_q;
  assign bus.mem_req     = (state_q == MEM_WAIT);
  assign bus.mem_addr    = bus.mem_req ? addr_q : '0;
  assign bus.l1_hit_cnt  = l1_cnt_q;
  assign bus.l2_hit_cnt  = l2_cnt_q;
  assign bus.miss_cnt    = miss_cnt_q;

endmodule

// File: tb/tb_cache_hier_nway.sv
// Scoreboard bench for cache_hier_nway: directed reads, a delayed-ack memory
// model, a response monitor, and a second instance with 2-bit counters.
module tb_cache_hier_nway;
  localparam int AW = 11;
  localparam int DW = 32;
  localparam int CW = 16;

  typedef struct {
    logic [DW-1:0] data;
    logic          l1;
    logic          l2;
    int            lat;  // accept-to-response cycles; 0 means measure from mem_ack
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_hier_nway_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();
  cache_hier_nway_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(2))  sbus ();

  cache_hier_nway #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAYS(4), .L1_SETS(4), .L2_SETS(16), .CNT_WIDTH(CW)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  cache_hier_nway #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAYS(4), .L1_SETS(4), .L2_SETS(16), .CNT_WIDTH(2)
  ) dut_sat (.clk(clk), .rst(rst), .bus(sbus));

  exp_t          sb[$];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            acc_cyc = 0;
  int            ack_cyc = 0;
  int            mem_req_seen = 0;
  int            mem_delay = 3;
  int            req_cnt = 0;
  logic          inject_ack = 1'b0;
  logic          prev_valid = 1'b0;
  logic [AW-1:0] cur_addr = '0;
  logic [AW-1:0] first_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] model(input logic [AW-1:0] a);
    return 32'hA5A5_0000 | DW'(a);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: acks mem_delay cycles after mem_req first appears.
  always @(negedge clk) begin
    bus.mem_ack = inject_ack;
    inject_ack  = 1'b0;
    if (rst) begin
      req_cnt = 0;
    end else if (bus.mem_req) begin
      if (req_cnt == 0) begin
        first_addr = bus.mem_addr;
        mem_req_seen++;
        check("mem_addr", 64'(bus.mem_addr), 64'(cur_addr));
      end else begin
        check("mem_addr_stable", 64'(bus.mem_addr), 64'(first_addr));
      end
      if (req_cnt == mem_delay) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = model(bus.mem_addr);
        ack_cyc       = cyc;
        req_cnt       = 0;
      end else begin
        req_cnt++;
      end
    end else begin
      req_cnt = 0;
    end
  end

  always @(negedge clk) begin
    sbus.mem_ack   = sbus.mem_req && !sbus.mem_ack;
    sbus.mem_rdata = 32'h1234_0000 | DW'(sbus.mem_addr);
  end

  // Response monitor.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.resp_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got data 0x%0h, expected no response", bus.resp_data);
      end else begin
        e = sb.pop_front();
        check("resp_data", 64'(bus.resp_data), 64'(e.data));
        check("resp_l1_hit", 64'(bus.resp_l1_hit), 64'(e.l1));
        check("resp_l2_hit", 64'(bus.resp_l2_hit), 64'(e.l2));
        if (e.lat > 0) check("resp_latency", 64'(cyc - acc_cyc), 64'(e.lat));
        else           check("resp_after_ack", 64'(cyc - ack_cyc), 64'(2));
      end
    end else if (!rst && prev_valid) begin
      check("resp_outputs_cleared",
            64'({bus.resp_valid, bus.resp_l1_hit, bus.resp_l2_hit, bus.resp_data}), 64'(0));
    end
    prev_valid = bus.resp_valid;
  end

  task automatic rd(input logic [AW-1:0] a, input bit push, input bit l1, input bit l2,
                    input int lat);
    int n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", 64'(bus.req_ready), 64'(1));
    cur_addr = a;
    if (push) sb.push_back('{data: model(a), l1: l1, l2: l2, lat: lat});
    acc_cyc       = cyc;
    bus.req_addr  = a;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (push) begin
      n = 0;
      while (sb.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (sb.size() != 0) begin
        total++;
        bad++;
        $display("FAIL resp_timeout: addr 0x%0h got no response, expected one", a);
        sb.delete();
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int n;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.mem_rdata  = '0;
    sbus.req_valid = 1'b0;
    sbus.req_addr  = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready), 64'(1));
    check("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
    check("rst_mem_req", 64'(bus.mem_req), 64'(0));
    check("rst_counters", 64'({bus.l1_hit_cnt, bus.l2_hit_cnt, bus.miss_cnt}), 64'(0));
    rst = 1'b0;

    // Cold miss then L1 hit on the same word.
    rd(11'h005, 1, 0, 0, 0);
    check("cold_miss_cnt", 64'(bus.miss_cnt), 64'(1));
    check("cold_mem_reqs", 64'(mem_req_seen), 64'(1));
    rd(11'h005, 1, 1, 0, 2);
    check("hit_l1_cnt", 64'(bus.l1_hit_cnt), 64'(1));
    check("hit_no_mem_req", 64'(mem_req_seen), 64'(1));

    // Fill L1 set 1 past capacity: 0x001 becomes the LRU victim.
    rd(11'h001, 1, 0, 0, 0);
    rd(11'h005, 1, 1, 0, 2);
    rd(11'h009, 1, 0, 0, 0);
    rd(11'h00D, 1, 0, 0, 0);
    rd(11'h011, 1, 0, 0, 0);
    n0 = mem_req_seen;
    rd(11'h001, 1, 0, 1, 4);
    check("l2_hit_no_mem_req", 64'(mem_req_seen), 64'(n0));
    rd(11'h001, 1, 1, 0, 2);
    check("evict_l1_cnt", 64'(bus.l1_hit_cnt), 64'(3));
    check("evict_l2_cnt", 64'(bus.l2_hit_cnt), 64'(1));
    check("evict_miss_cnt", 64'(bus.miss_cnt), 64'(5));

    // LRU order in L1 set 2: A,B,C,D, touch A, fill E evicts B.
    rd(11'h002, 1, 0, 0, 0);
    rd(11'h006, 1, 0, 0, 0);
    rd(11'h00A, 1, 0, 0, 0);
    rd(11'h00E, 1, 0, 0, 0);
    rd(11'h002, 1, 1, 0, 2);
    rd(11'h012, 1, 0, 0, 0);
    rd(11'h002, 1, 1, 0, 2);
    rd(11'h00A, 1, 1, 0, 2);
    rd(11'h00E, 1, 1, 0, 2);
    rd(11'h006, 1, 0, 1, 4);
    check("lru_l1_cnt", 64'(bus.l1_hit_cnt), 64'(7));
    check("lru_l2_cnt", 64'(bus.l2_hit_cnt), 64'(2));
    check("lru_miss_cnt", 64'(bus.miss_cnt), 64'(10));

    // Reset while waiting on memory, then a stray late ack.
    mem_delay = 20;
    rd(11'h100, 0, 0, 0, 0);
    n = 0;
    while (!bus.mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("abort_mem_req_seen", 64'(bus.mem_req), 64'(1));
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_mem_req", 64'(bus.mem_req), 64'(0));
    check("abort_resp_valid", 64'(bus.resp_valid), 64'(0));
    check("abort_counters", 64'({bus.l1_hit_cnt, bus.l2_hit_cnt, bus.miss_cnt}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    mem_delay = 3;
    @(posedge clk);
    #1 inject_ack = 1'b1;
    repeat (3) @(negedge clk);
    check("late_ack_ignored", 64'({bus.req_ready, bus.mem_req}), 64'(2'b10));
    n0 = mem_req_seen;
    rd(11'h100, 1, 0, 0, 0);
    check("post_abort_mem_req", 64'(mem_req_seen), 64'(n0 + 1));
    rd(11'h005, 1, 0, 0, 0);
    check("post_abort_miss_cnt", 64'(bus.miss_cnt), 64'(2));

    // Saturation on the 2-bit counter instance: one miss then five L1 hits.
    for (int i = 0; i < 6; i++) begin
      n = 0;
      @(negedge clk);
      while (!sbus.req_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      sbus.req_addr  = 11'h007;
      sbus.req_valid = 1'b1;
      @(negedge clk);
      sbus.req_valid = 1'b0;
    end
    n = 0;
    while (!sbus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("sat_l1_hit_cnt", 64'(sbus.l1_hit_cnt), 64'(3));
    check("sat_miss_cnt", 64'(sbus.miss_cnt), 64'(1));
    check("sat_l2_hit_cnt", 64'(sbus.l2_hit_cnt), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
